// File: rtl/pixel_plot_receiver.sv
// Buffers plot requests from the drawing datapath in a small in-order FIFO and
// turns each one into a single framebuffer write (IDLE -> CALC -> WRITE).
module pixel_plot_receiver #(
    parameter int FIFO_DEPTH = 4,
    parameter int SCREEN_W   = 160,
    parameter int SCREEN_H   = 120
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  x,
    input  logic [7:0]  y,
    input  logic [2:0]  colour,
    input  logic        plot,
    output logic        ready,
    output logic [14:0] mem_addr,
    output logic [2:0]  mem_data,
    output logic        mem_we,
    input  logic        mem_ack,
    output logic [7:0]  drop_count,
    output logic        idle
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [8:0]       SCREEN_W9 = 9'(SCREEN_W);
    localparam logic [8:0]       SCREEN_H9 = 9'(SCREEN_H);
    localparam logic [14:0]      SCREEN_W15 = 15'(SCREEN_W);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_WRITE
    } state_t;

    state_t state_q, state_d;

    logic [18:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [7:0]  hold_x_q, hold_x_d;
    logic [7:0]  hold_y_q, hold_y_d;
    logic [2:0]  hold_c_q, hold_c_d;
    logic [14:0] addr_q, addr_d;
    logic [2:0]  data_q, data_d;
    logic [7:0]  drop_q, drop_d;

    logic           in_range;
    logic           accept;
    logic           push;
    logic           pop;
    logic           busy;
    logic [CNT_W:0] occupancy;

    // The request parked in the holding registers still counts against capacity,
    // so a stalled write leaves room for FIFO_DEPTH-1 queued requests.
    always_comb begin
        busy      = (state_q != ST_IDLE);
        occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, busy};
        ready     = reset_n && (occupancy < DEPTH_C);
        in_range  = ({1'b0, x} < SCREEN_W9) && ({1'b0, y} < SCREEN_H9);
        accept    = plot && ready;
        push      = accept && in_range;
        pop       = (state_q == ST_IDLE) && (count_q != '0);
        idle      = (count_q == '0) && (state_q == ST_IDLE);
        mem_we    = (state_q == ST_WRITE);
        mem_addr  = addr_q;
        mem_data  = data_q;
        drop_count = drop_q;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;

        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (accept && !in_range && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_comb begin
        state_d  = state_q;
        hold_x_d = hold_x_q;
        hold_y_d = hold_y_q;
        hold_c_d = hold_c_q;
        addr_d   = addr_q;
        data_d   = data_q;

        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    {hold_x_d, hold_y_d, hold_c_d} = fifo_mem[rd_ptr_q];
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                // Constant multiplier: synthesis reduces it to shifts and adds.
                addr_d  = 15'(hold_y_q) * SCREEN_W15 + 15'(hold_x_q);
                data_d  = hold_c_q;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (mem_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {x, y, colour};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_x_q <= '0;
            hold_y_q <= '0;
            hold_c_q <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hold_x_q <= hold_x_d;
            hold_y_q <= hold_y_d;
            hold_c_q <= hold_c_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            drop_q   <= drop_d;
        end
    end

endmodule

// File: tb/tb_pixel_plot_receiver.sv
// Directed test of pixel_plot_receiver: latency, corners, drops, backpressure,
// sprite ordering and reset in the middle of a write.
module tb_pixel_plot_receiver;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        ready;
    logic [14:0] mem_addr;
    logic [2:0]  mem_data;
    logic        mem_we;
    logic        mem_ack;
    logic [7:0]  drop_count;
    logic        idle;

    int vectors = 0;
    int miscompares = 0;

    pixel_plot_receiver dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .ready      (ready),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_we     (mem_we),
        .mem_ack    (mem_ack),
        .drop_count (drop_count),
        .idle       (idle)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("miscompare on %s", tag);
        end
    endtask

    // Bounded wait for the next write strobe; a timeout shows up as mem_we=0.
    task automatic wait_we(input string tag);
        for (int i = 0; i < 12 && !mem_we; i++) tick();
        check(tag, 32'(mem_we), 32'd1);
    endtask

    initial begin
        int accepted;
        int wcnt;
        int idx;
        bit acc;

        reset_n = 1'b0; plot = 1'b0; mem_ack = 1'b0;
        x = '0; y = '0; colour = '0;
        tick();
        tick();
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);
        check("rst_idle", 32'(idle), 32'd1);
        reset_n = 1'b1;
        #1;
        check("rel_ready", 32'(ready), 32'd1);

        // Single pixel: 60*160+10 = 9610, strobe after the second edge.
        mem_ack = 1'b1;
        x = 8'd10; y = 8'd60; colour = 3'b101; plot = 1'b1;
        tick();
        plot = 1'b0;
        check("px_we_e0", 32'(mem_we), 32'd0);
        check("px_idle_e0", 32'(idle), 32'd0);
        tick();
        check("px_we_e1", 32'(mem_we), 32'd0);
        tick();
        check("px_we_e2", 32'(mem_we), 32'd1);
        check("px_addr", 32'(mem_addr), 32'd9610);
        check("px_data", 32'(mem_data), 32'd5);
        tick();
        check("px_we_done", 32'(mem_we), 32'd0);
        check("px_idle", 32'(idle), 32'd1);
        check("px_addr_hold", 32'(mem_addr), 32'd9610);

        // Bottom-right corner and the first out-of-range column.
        x = 8'd159; y = 8'd119; colour = 3'b111; plot = 1'b1;
        tick();
        plot = 1'b0;
        wait_we("corner_we");
        check("corner_addr", 32'(mem_addr), 32'd19199);
        tick();
        x = 8'd160; y = 8'd0; plot = 1'b1;
        tick();
        plot = 1'b0;
        check("drop_one", 32'(drop_count), 32'd1);
        wcnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (mem_we) wcnt++;
            tick();
        end
        check("drop_nowrite", 32'(wcnt), 32'd0);
        check("drop_idle", 32'(idle), 32'd1);

        // Backpressure: four requests fit (three queued, one held), fifth refused.
        mem_ack = 1'b0;
        accepted = 0;
        for (int i = 0; i < 5; i++) begin
            x = 8'(20 + i); y = 8'd30; colour = 3'(i); plot = 1'b1;
            check($sformatf("bp_ready%0d", i), 32'(ready), (i < 4) ? 32'd1 : 32'd0);
            if (ready) accepted++;
            tick();
        end
        plot = 1'b0;
        check("bp_accepted", 32'(accepted), 32'd4);
        for (int i = 0; i < 3; i++) begin
            check("bp_stall_we", 32'(mem_we), 32'd1);
            check("bp_stall_addr", 32'(mem_addr), 32'd4820);
            tick();
        end
        mem_ack = 1'b1;
        wcnt = 0;
        for (int i = 0; i < 40 && wcnt < 4; i++) begin
            if (mem_we) begin
                check($sformatf("bp_addr%0d", wcnt), 32'(mem_addr), 32'(4820 + wcnt));
                check($sformatf("bp_data%0d", wcnt), 32'(mem_data), 32'(wcnt));
                wcnt++;
            end
            tick();
        end
        check("bp_writes", 32'(wcnt), 32'd4);
        tick();
        check("bp_idle", 32'(idle), 32'd1);

        // 4x4 sprite in raster order, pushing whenever ready.
        idx = 0;
        wcnt = 0;
        for (int cyc = 0; cyc < 200 && wcnt < 16; cyc++) begin
            if (idx < 16) begin
                x = 8'(10 + idx % 4); y = 8'(60 + idx / 4); colour = 3'(idx % 8); plot = 1'b1;
            end else begin
                plot = 1'b0;
            end
            acc = ready && plot;
            tick();
            if (acc) idx++;
            if (mem_we) begin
                check($sformatf("spr_addr%0d", wcnt), 32'(mem_addr),
                      32'((60 + wcnt / 4) * 160 + 10 + wcnt % 4));
                check($sformatf("spr_data%0d", wcnt), 32'(mem_data), 32'(wcnt % 8));
                wcnt++;
            end
        end
        plot = 1'b0;
        check("spr_writes", 32'(wcnt), 32'd16);
        check("spr_drops", 32'(drop_count), 32'd1);

        // Saturation: 300 more out-of-range requests.
        x = 8'd200; y = 8'd10; plot = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        plot = 1'b0;
        check("sat_drop", 32'(drop_count), 32'd255);
        check("sat_idle", 32'(idle), 32'd1);

        // Reset while a write is pending, with a second request queued behind it.
        mem_ack = 1'b0;
        x = 8'd5; y = 8'd5; plot = 1'b1;
        tick();
        x = 8'd6;
        tick();
        plot = 1'b0;
        wait_we("rw_we");
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        #1;
        check("rw_we_after", 32'(mem_we), 32'd0);
        check("rw_idle", 32'(idle), 32'd1);
        check("rw_ready", 32'(ready), 32'd1);
        check("rw_drop", 32'(drop_count), 32'd0);
        check("rw_addr", 32'(mem_addr), 32'd0);
        mem_ack = 1'b1;
        wcnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (mem_we) wcnt++;
        end
        check("rw_nowrite", 32'(wcnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pixel_plot_receiver.md
PIXEL_PLOT_RECEIVER -- requirements
Module: pixel_plot_receiver

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of buffered plot requests.
REQ-002 SHALL have parameter SCREEN_W, default 160, screen width in pixels.
REQ-003 SHALL have parameter SCREEN_H, default 120, screen height in pixels.
REQ-004 SHALL have port clock  input  1  rising-edge system clock.
REQ-005 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port x  input  8  pixel column from the drawing datapath.
REQ-007 SHALL have port y  input  8  pixel row from the drawing datapath.
REQ-008 SHALL have port colour  input  3  pixel colour; 3'b000 is the erase colour and is written like any other.
REQ-009 SHALL have port plot  input  1  request valid.
REQ-010 SHALL have port ready  output  1  request can be taken this cycle.
REQ-011 SHALL have port mem_addr  output  15  framebuffer word address.
REQ-012 SHALL have port mem_data  output  3  framebuffer write data.
REQ-013 SHALL have port mem_we  output  1  framebuffer write strobe.
REQ-014 SHALL have port mem_ack  input  1  framebuffer accepted the write this cycle.
REQ-015 SHALL have port drop_count  output  8  count of out-of-range requests, saturating.
REQ-016 SHALL have port idle  output  1  FIFO empty and FSM in IDLE.

Function
REQ-017 A request SHALL be accepted on a rising edge where plot=1 and ready=1; plot is ignored when ready=0.
REQ-018 ready SHALL be 1 when FIFO occupancy < FIFO_DEPTH and reset_n=1, else 0; it SHALL NOT depend on a same-cycle pop, so there is no pass-through when full.
REQ-019 An accepted request with x>=SCREEN_W or y>=SCREEN_H SHALL NOT be pushed, and drop_count SHALL increment, saturating at 255.
REQ-020 An accepted in-range request SHALL push {x,y,colour} into the FIFO, which is strictly in-order.
REQ-021 The FSM SHALL have three states: IDLE, CALC and WRITE.
REQ-022 In IDLE, if the FIFO is non-empty, the FSM SHALL pop the head into holding registers and go to CALC; otherwise it SHALL stay in IDLE.
REQ-023 In CALC, the FSM SHALL register mem_addr = y*SCREEN_W + x, computed shift-add as (y<<7)+(y<<5)+x for the default, at 15-bit width with no truncation (max 19199); it SHALL register mem_data = colour and go to WRITE.
REQ-024 In WRITE, mem_we SHALL be 1 and mem_addr/mem_data SHALL be held stable until a cycle with mem_ack=1, after which the FSM SHALL go to IDLE.
REQ-025 mem_ack SHALL be ignored outside WRITE.
REQ-026 mem_we SHALL be 0 in IDLE and CALC.
REQ-027 Latency: a request accepted at edge E into an empty FIFO with the FSM in IDLE SHALL have mem_we=1 in the cycle following edge E+2.
REQ-028 Throughput SHALL be at most one write per 3 cycles with mem_ack tied high.
REQ-029 A push and a pop on the same edge SHALL leave occupancy unchanged; the FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-030 idle SHALL be 1 exactly when occupancy=0 and state=IDLE.
REQ-031 mem_addr and mem_data SHALL retain their last values outside WRITE.

Reset
REQ-032 On a rising edge with reset_n=0, the block SHALL set state=IDLE, FIFO occupancy=0 with pointers at 0, mem_we=0, mem_addr=0, mem_data=0 and drop_count=0.
REQ-033 Reset during WRITE SHALL abandon the pending write with no mem_we in the following cycle, and all buffered requests SHALL be discarded.
REQ-034 ready SHALL be 0 while reset_n=0 and 1 in the first cycle after reset is released.

Verification
REQ-035 Single pixel: plot x=10, y=60, colour=3'b101, mem_ack=1 -> mem_we=1 two edges after acceptance with mem_addr=9610 and mem_data=5, then idle=1.
REQ-036 Corner: x=159, y=119 -> mem_addr=19199; x=160, y=0 -> no write and drop_count=1; 300 out-of-range requests -> drop_count=255.
REQ-037 Backpressure: mem_ack=0 with 5 back-to-back plots -> 4 accepted, then ready=0 (FIFO 3 + 1 in holding); mem_addr is stable while stalled; releasing mem_ack -> all writes emerge in order.
REQ-038 4x4 sprite: 16 plots from x 10..13, y 60..63 with mem_ack=1 -> 16 writes in raster order, no drops.
REQ-039 Reset mid-WRITE: assert reset_n=0 for one edge while mem_we=1 -> next cycle mem_we=0, idle=1, ready=1, no further writes.
